// File: rtl/pi_dma_defs.sv
// rtl/pi_dma_defs.sv - shared definitions for the PI DMA controller
// Purpose: region codes, controller state encoding and PI address width
//          shared by pi_dma_ctrl and pi_acc_timer.
// Ports:   none (package).
package pi_dma_defs;

   localparam int PI_AW = 23;

   typedef enum logic [1:0] {
      REG_PRG = 2'd0,
      REG_CHR = 2'd1,
      REG_SRM = 2'd2,
      REG_RSV = 2'd3
   } pi_reg_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ARB  = 3'd1,
      ST_WDAT = 3'd2,
      ST_ACC  = 3'd3,
      ST_GAP  = 3'd4,
      ST_RDAT = 3'd5,
      ST_FIN  = 3'd6
   } pi_state_e;

endpackage

// File: rtl/pi_acc_timer.sv
// rtl/pi_acc_timer.sv - per-byte access wait-state down-counter
// Purpose: counts the clocks a byte access holds CE plus OE/WE.
// Ports:   clk, rst  - clock, asynchronous active-high reset
//          load      - preset the counter to ACC_CYC (clock before ACC)
//          run       - decrement while the access is in progress
//          expire    - high during the last access clock
module pi_acc_timer #(
   parameter int ACC_CYC = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic run,
   output logic expire
);

   logic [3:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= 4'(ACC_CYC);
      end else if (run && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Preset to ACC_CYC on entry, so a value of 1 marks the final clock.
   assign expire = (cnt == 4'd1);

endmodule

// File: rtl/pi_dma_ctrl.sv
// rtl/pi_dma_ctrl.sv - MCU block command to byte-wide PI bus cycle sequencer
// Purpose: turns a block transfer command into per-byte PI accesses with
//          address increment, wait states and stream flow control.
// Ports:   cmd_*          - command handshake (wr, region, start addr, len)
//          abort          - stop after the byte currently in flight
//          wr_dat/valid/ready - write byte stream in
//          rd_dat/valid/ready - read byte stream out
//          pi_*           - PI bus towards the mapper
//          busy/done/err  - status; done and err are single-clock pulses
//          csum           - running byte sum (only with PI_DMA_CSUM_EN)
// Macro:   PI_DMA_CSUM_EN adds the csum output and its adder.
module pi_dma_ctrl
   import pi_dma_defs::*;
#(
   parameter int ACC_CYC = 4,
   parameter int LEN_W   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_wr,
   input  logic [1:0]          cmd_reg,
   input  logic [PI_AW-1:0]    cmd_addr,
   input  logic [LEN_W-1:0]    cmd_len,
   input  logic                abort,
   input  logic [7:0]          wr_dat,
   input  logic                wr_valid,
   output logic                wr_ready,
   output logic [7:0]          rd_dat,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [PI_AW-1:0]    pi_addr,
   output logic [7:0]          pi_do,
   input  logic [7:0]          pi_di,
   output logic                pi_we,
   output logic                pi_oe,
   output logic                pi_ce_prg,
   output logic                pi_ce_chr,
   output logic                pi_ce_srm,
   output logic                pi_dma_req,
   output logic                busy,
   output logic                done,
   output logic                err
`ifdef PI_DMA_CSUM_EN
   ,
   output logic [15:0]         csum
`endif
);

   // One extra bit so a zero length can hold 2^LEN_W.
   localparam int RW = LEN_W + 1;

   pi_state_e         state, nxt;
   logic              wr_q;
   pi_reg_e           reg_q;
   logic [RW-1:0]     rem_q;
   logic              abort_q;
   logic              abort_any;
   logic              accept, reject, take_wr, tmr_load, tmr_expire;
   logic              rd_sample;
   logic              nxt_active;

   assign abort_any = abort | abort_q;
   assign rd_sample = (state == ST_ACC) && tmr_expire && !wr_q;
   assign nxt_active = (nxt == ST_ARB) || (nxt == ST_WDAT) || (nxt == ST_ACC) ||
                       (nxt == ST_GAP) || (nxt == ST_RDAT);

   pi_acc_timer #(
      .ACC_CYC (ACC_CYC)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (tmr_load),
      .run    (state == ST_ACC),
      .expire (tmr_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt      = state;
      accept   = 1'b0;
      reject   = 1'b0;
      take_wr  = 1'b0;
      tmr_load = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (pi_reg_e'(cmd_reg) == REG_RSV) begin
                  reject = 1'b1;
               end else begin
                  accept = 1'b1;
                  nxt    = ST_ARB;
               end
            end
         end
         ST_ARB: begin
            if (abort_any) begin
               nxt = ST_FIN;
            end else if (wr_q) begin
               nxt = ST_WDAT;
            end else begin
               nxt      = ST_ACC;
               tmr_load = 1'b1;
            end
         end
         ST_WDAT: begin
            // A byte offered together with abort has already handshaken,
            // so it is written and the transfer ends after it.
            if (wr_valid) begin
               take_wr  = 1'b1;
               tmr_load = 1'b1;
               nxt      = ST_ACC;
            end else if (abort_any) begin
               nxt = ST_FIN;
            end
         end
         ST_ACC: begin
            if (tmr_expire) begin
               nxt = ST_GAP;
            end
         end
         ST_GAP: begin
            if (!wr_q) begin
               nxt = ST_RDAT;
            end else if (rem_q == RW'(1) || abort_any) begin
               nxt = ST_FIN;
            end else begin
               nxt = ST_WDAT;
            end
         end
         ST_RDAT: begin
            // rem_q was already decremented in GAP.
            if (rd_ready) begin
               if (rem_q == '0 || abort_any) begin
                  nxt = ST_FIN;
               end else begin
                  nxt      = ST_ACC;
                  tmr_load = 1'b1;
               end
            end
         end
         ST_FIN: begin
            nxt = ST_IDLE;
         end
         default: begin
            nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered copies of what the next state implies, so
   // every strobe lines up exactly with the state it belongs to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q       <= 1'b0;
         reg_q      <= REG_PRG;
         rem_q      <= '0;
         abort_q    <= 1'b0;
         cmd_ready  <= 1'b1;
         wr_ready   <= 1'b0;
         rd_valid   <= 1'b0;
         rd_dat     <= '0;
         pi_addr    <= '0;
         pi_do      <= '0;
         pi_we      <= 1'b0;
         pi_oe      <= 1'b0;
         pi_ce_prg  <= 1'b0;
         pi_ce_chr  <= 1'b0;
         pi_ce_srm  <= 1'b0;
         pi_dma_req <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         cmd_ready  <= (nxt == ST_IDLE);
         wr_ready   <= (nxt == ST_WDAT);
         rd_valid   <= (nxt == ST_RDAT);
         pi_dma_req <= nxt_active;
         busy       <= nxt_active;
         done       <= (nxt == ST_FIN);
         err        <= reject;
         pi_ce_prg  <= (nxt == ST_ACC) && (reg_q == REG_PRG);
         pi_ce_chr  <= (nxt == ST_ACC) && (reg_q == REG_CHR);
         pi_ce_srm  <= (nxt == ST_ACC) && (reg_q == REG_SRM);
         pi_oe      <= (nxt == ST_ACC) && !wr_q;
         pi_we      <= (nxt == ST_ACC) && wr_q;

         if (accept) begin
            wr_q    <= cmd_wr;
            reg_q   <= pi_reg_e'(cmd_reg);
            pi_addr <= cmd_addr;
            rem_q   <= (cmd_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cmd_len};
            abort_q <= 1'b0;
         end else if (state == ST_FIN) begin
            abort_q <= 1'b0;
         end else if (abort && state != ST_IDLE) begin
            abort_q <= 1'b1;
         end

         if (take_wr) begin
            pi_do <= wr_dat;
         end

         if (rd_sample) begin
            rd_dat <= pi_di;
         end

         if (state == ST_GAP) begin
            pi_addr <= pi_addr + PI_AW'(1);
            rem_q   <= rem_q - RW'(1);
         end
      end
   end

`ifdef PI_DMA_CSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csum <= '0;
      end else if (accept) begin
         csum <= '0;
      end else if (take_wr) begin
         csum <= csum + {8'd0, wr_dat};
      end else if (rd_sample) begin
         csum <= csum + {8'd0, pi_di};
      end
   end
`endif

endmodule
